// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle execute unit. Logic, compare and add/sub finish
//                in one cycle; shifts iterate one bit per cycle behind a
//                start/busy/done handshake so no barrel shifter is needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            err
);

    // Operation codes produced by the ALU decoder
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_SLT  = 4'b0101;
    localparam logic [3:0] c_OP_XOR  = 4'b0110;
    localparam logic [3:0] c_OP_SLL  = 4'b0111;
    localparam logic [3:0] c_OP_SRL  = 4'b1000;
    localparam logic [3:0] c_OP_SRA  = 4'b1001;
    localparam logic [3:0] c_OP_SLTU = 4'b1100;

    // Latched shift direction while iterating
    localparam logic [1:0] c_SH_SLL = 2'd0;
    localparam logic [1:0] c_SH_SRL = 2'd1;
    localparam logic [1:0] c_SH_SRA = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q,  state_d;
    logic [XLEN-1:0] acc_q,    acc_d;
    logic [4:0]      cnt_q,    cnt_d;
    logic [1:0]      shtype_q, shtype_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q,   done_d;
    logic            err_q,    err_d;

    logic [XLEN-1:0] w_alu_val;
    logic            w_is_shift;
    logic            w_illegal;
    logic [1:0]      w_new_shtype;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;

    assign w_shamt = SrcB[4:0];

    // Single-cycle datapath and decode of the incoming operation code
    always_comb begin
        w_alu_val    = '0;
        w_is_shift   = 1'b0;
        w_illegal    = 1'b0;
        w_new_shtype = c_SH_SLL;
        case (ALUControl)
            c_OP_ADD:  w_alu_val = SrcA + SrcB;
            c_OP_SUB:  w_alu_val = SrcA - SrcB;
            c_OP_AND:  w_alu_val = SrcA & SrcB;
            c_OP_OR:   w_alu_val = SrcA | SrcB;
            c_OP_XOR:  w_alu_val = SrcA ^ SrcB;
            c_OP_SLT:  w_alu_val = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            c_OP_SLTU: w_alu_val = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            // A zero-amount shift returns the operand untouched
            c_OP_SLL: begin
                w_alu_val    = SrcA;
                w_is_shift   = 1'b1;
                w_new_shtype = c_SH_SLL;
            end
            c_OP_SRL: begin
                w_alu_val    = SrcA;
                w_is_shift   = 1'b1;
                w_new_shtype = c_SH_SRL;
            end
            c_OP_SRA: begin
                w_alu_val    = SrcA;
                w_is_shift   = 1'b1;
                w_new_shtype = c_SH_SRA;
            end
            default:   w_illegal = 1'b1;
        endcase
    end

    // One-bit step of the working register in the latched direction
    always_comb begin
        w_shifted = acc_q;
        case (shtype_q)
            c_SH_SLL: w_shifted = {acc_q[XLEN-2:0], 1'b0};
            c_SH_SRL: w_shifted = {1'b0, acc_q[XLEN-1:1]};
            c_SH_SRA: w_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default:  w_shifted = acc_q;
        endcase
    end

    // Next-state logic: accept in IDLE, iterate in SHIFT, flush aborts silently
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        shtype_d = shtype_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (w_illegal) begin
                        result_d = '0;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                    end else if (w_is_shift && (w_shamt != 5'd0)) begin
                        acc_d    = SrcA;
                        cnt_d    = w_shamt;
                        shtype_d = w_new_shtype;
                        state_d  = ST_SHIFT;
                    end else begin
                        result_d = w_alu_val;
                        done_d   = 1'b1;
                        err_d    = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    // Result and err keep their old values; no done
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_shifted;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_d = w_shifted;
                        done_d   = 1'b1;
                        err_d    = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= 5'd0;
            shtype_q <= c_SH_SLL;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            shtype_q <= shtype_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = (result_q == '0);
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        err;

    int n_checks;
    int n_fail;

    seq_alu #(.XLEN(32)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush      (flush),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns in cycle 1 of the operation
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        start      = 1'b1;
        ALUControl = ctl;
        SrcA       = a;
        SrcB       = b;
        tick();
        start      = 1'b0;
    endtask

    // Wait (bounded) until done, reporting the cycle number it appeared in
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!done && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    task automatic count_dones(input int ncyc, output int ndone);
        ndone = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (done) ndone++;
        end
    endtask

    int lat;
    int nd;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        ALUControl = 4'd0;
        SrcA       = '0;
        SrcB       = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", ALUResult,      32'd0);
        check("rst_zero",   {31'd0, Zero}, 32'd1);
        check("rst_err",    {31'd0, err},  32'd0);

        // add wrap, then sub back-to-back
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1);
        check("add_done",   {31'd0, done}, 32'd1);
        check("add_busy",   {31'd0, busy}, 32'd0);
        check("add_result", ALUResult,      32'd0);
        check("add_zero",   {31'd0, Zero}, 32'd1);
        issue(4'b0001, 32'd5, 32'd5);
        check("sub_done",   {31'd0, done}, 32'd1);
        check("sub_result", ALUResult,      32'd0);
        check("sub_zero",   {31'd0, Zero}, 32'd1);
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);

        // compares and logic
        issue(4'b0101, 32'hFFFF_FFFF, 32'd1);
        check("slt_result", ALUResult, 32'd1);
        check("slt_zero",   {31'd0, Zero}, 32'd0);
        issue(4'b1100, 32'hFFFF_FFFF, 32'd1);
        check("sltu_result", ALUResult, 32'd0);
        issue(4'b0110, 32'hF0F0_F0F0, 32'hFFFF_0000);
        check("xor_result", ALUResult, 32'h0F0F_F0F0);
        issue(4'b0011, 32'h0000_00F0, 32'h0000_000F);
        check("or_result",  ALUResult, 32'h0000_00FF);
        issue(4'b0010, 32'h0000_00F0, 32'h0000_003C);
        check("and_result", ALUResult, 32'h0000_0030);
        tick();

        // arithmetic shift by 31
        issue(4'b1001, 32'h8000_0000, 32'h0000_003F);
        check("sra_busy1", {31'd0, busy}, 32'd1);
        check("sra_done1", {31'd0, done}, 32'd0);
        wait_done(1, lat);
        check("sra_latency", lat, 32'd32);
        check("sra_result",  ALUResult, 32'hFFFF_FFFF);
        check("sra_busy_end", {31'd0, busy}, 32'd0);
        tick();
        issue(4'b1000, 32'h8000_0000, 32'h0000_003F);
        wait_done(1, lat);
        check("srl_latency", lat, 32'd32);
        check("srl_result",  ALUResult, 32'h0000_0001);
        tick();
        issue(4'b0111, 32'd1, 32'd4);
        wait_done(1, lat);
        check("sll_latency", lat, 32'd5);
        check("sll_result",  ALUResult, 32'h0000_0010);
        tick();

        // zero shift and illegal code
        issue(4'b0111, 32'h0000_1234, 32'hFFFF_FFE0);
        check("sh0_done",   {31'd0, done}, 32'd1);
        check("sh0_busy",   {31'd0, busy}, 32'd0);
        check("sh0_result", ALUResult, 32'h0000_1234);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        check("ill_done",   {31'd0, done}, 32'd1);
        check("ill_result", ALUResult, 32'd0);
        check("ill_err",    {31'd0, err},  32'd1);
        check("ill_zero",   {31'd0, Zero}, 32'd1);
        issue(4'b0000, 32'd2, 32'd3);
        check("err_clear",  {31'd0, err},  32'd0);
        tick();

        // start while busy is ignored
        issue(4'b1000, 32'h0000_0100, 32'd8);
        tick();
        tick();
        start      = 1'b1;
        ALUControl = 4'b0000;
        SrcA       = 32'd7;
        SrcB       = 32'd7;
        tick();
        start = 1'b0;
        check("ign_done4", {31'd0, done}, 32'd0);
        wait_done(4, lat);
        check("ign_latency", lat, 32'd9);
        check("ign_result",  ALUResult, 32'h0000_0001);
        issue(4'b0000, 32'd2, 32'd3);
        check("b2b_done",   {31'd0, done}, 32'd1);
        check("b2b_result", ALUResult, 32'd5);
        tick();

        // flush mid-shift
        issue(4'b0111, 32'd1, 32'd20);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy",   {31'd0, busy}, 32'd0);
        check("flush_done",   {31'd0, done}, 32'd0);
        check("flush_result", ALUResult, 32'd5);
        count_dones(25, nd);
        check("flush_nodone", nd, 32'd0);
        check("flush_hold",   ALUResult, 32'd5);

        // reset mid-shift
        issue(4'b0111, 32'd1, 32'd20);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy",   {31'd0, busy}, 32'd0);
        check("mrst_done",   {31'd0, done}, 32'd0);
        check("mrst_result", ALUResult, 32'd0);
        check("mrst_zero",   {31'd0, Zero}, 32'd1);
        check("mrst_err",    {31'd0, err},  32'd0);
        count_dones(25, nd);
        check("mrst_nodone", nd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Multi-cycle execute unit for the RISC-V datapath that sits directly downstream of the ALU decoder and consumes its 4-bit `ALUControl` code. It executes the same operation set as the single-cycle ALU. Logic, compare and add/sub results are registered in one cycle. Shifts are performed iteratively, one bit per cycle, so the barrel shifter can be removed from the critical path. A start/busy/done handshake lets a multi-cycle control FSM stall on shifts.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Must be 32 in this core; the shift amount is always 5 bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; one clock, one synchronous active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `flush`  in  1  synchronous abort of any in-flight shift; no `done` is produced.
- `ALUControl`  in  4  operation code from the ALU decoder; sampled with `start`.
- `SrcA`  in  XLEN  operand A; sampled with `start`.
- `SrcB`  in  XLEN  operand B; `SrcB[4:0]` is the shift amount. Sampled with `start`.
- `busy`  out  1  high while a shift is iterating.
- `done`  out  1  one-cycle pulse; `ALUResult` is valid from this cycle onward.
- `ALUResult`  out  XLEN  registered result; held until the next `done`.
- `Zero`  out  1  `ALUResult`==0, derived from the registered result.
- `err`  out  1  registered with `done`; 1 if the accepted code was illegal.

## Operation
- Codes:
  - 0000 add
  - 0001 sub
  - 0101 slt (signed)
  - 1100 sltu (unsigned)
  - 0011 or
  - 0010 and
  - 0110 xor
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - any other code is illegal.
- Arithmetic: add/sub wrap modulo 2^32 with no overflow flag. slt/sltu produce {31'b0, lt}.
- Shift amount is `SrcB[4:0]`; `SrcB[31:5]` is ignored. sra replicates the operand's bit 31 on every step.
- FSM states:
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1; holds the working register `acc` and a 5-bit count `cnt`.
- IDLE with `start`=1 and `flush`=0:
  - Non-shift op, or shift with amount 0: `ALUResult`<=computed value (SrcA unchanged for a zero shift). `done`<=1, `err`<=0. Stay in IDLE.
  - Illegal code: `ALUResult`<=0, `done`<=1, `err`<=1. Stay in IDLE.
  - Shift with amount k>0: `acc`<=SrcA, `cnt`<=k, latch the shift type. Go to SHIFT.
- SHIFT, each cycle with `flush`=0:
  - `acc` shifts one bit in the latched direction and `cnt` decrements.
  - When `cnt`==1 at the edge: `ALUResult`<=shifted `acc`, `done`<=1, `err`<=0, go to IDLE.
- `flush`=1 has priority over `start`:
  - The FSM goes to IDLE and `done`<=0.
  - `ALUResult` and `err` keep their previous values.
- `start` while `busy`=1 is ignored. Its operands are not captured.
- `ALUResult`, `Zero` and `err` change only on a `done` edge or on reset.

## Timing
- Reset (`rst_n`=0 at an edge): IDLE, `busy`=0, `done`=0, `ALUResult`=0, `Zero`=1, `err`=0, `cnt`=0. Reset overrides `start` and `flush`. Reset mid-shift drops the operation with no `done`.
- Start sampled at the end of cycle 0:
  - Non-shift, zero-shift or illegal: `done`=1 in cycle 1, `busy` stays 0.
  - Shift by k>0: `busy`=1 in cycles 1..k, `done`=1 and `busy`=0 in cycle k+1. Latency is k+1 cycles, maximum 32 for k=31.
- `done` is high for exactly one cycle per accepted operation.
- Back-to-back: `start` in a `done` cycle (`busy`=0) is accepted. One-cycle ops can therefore complete every cycle.
- `flush` in cycle j of SHIFT: IDLE and `busy`=0 in cycle j+1, no `done`. `start` in the same cycle as `flush` is dropped.

## Test plan
- Add wrap and sub zero: add SrcA=0xFFFFFFFF, SrcB=1 -> `done` in cycle 1, `ALUResult`=0, `Zero`=1. Then sub 5-5 back-to-back -> `ALUResult`=0, `Zero`=1, `done` two consecutive cycles.
- Compare: slt 0xFFFFFFFF vs 1 -> 1; sltu with the same operands -> 0; xor 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
- Arithmetic shift: sra SrcA=0x80000000, SrcB=0x0000003F (amount 31) -> `busy` for 31 cycles, `done` in cycle 32, `ALUResult`=0xFFFFFFFF. srl with the same operands -> 0x00000001. sll 1 by 4 -> 0x10 in cycle 5.
- Zero shift and illegal code: sll with amount 0, SrcA=0x1234 -> `done` in cycle 1, result 0x1234. Code 1111 -> `done` in cycle 1, `ALUResult`=0, `err`=1, `Zero`=1.
- Ignored start: start srl 0x100 by 8; pulse `start` with add in cycle 3 -> ignored, `done` in cycle 9, `ALUResult`=0x1. A start issued in cycle 9 is accepted.
- Flush and reset mid-shift:
  - sll by 20, `flush` in cycle 5 -> `busy`=0 in cycle 6, no `done`, `ALUResult` unchanged.
  - Repeat with `rst_n`=0 in cycle 5 -> all outputs at reset values in cycle 6, no `done`.
